// File: rtl/add48_seq_ctrl.sv
// Sequenced 48-bit adder: one shared 16-bit slice is stepped across the operands,
// with the inter-slice carry held in a register. Start/busy/done handshake plus accumulate.
module add48_seq_ctrl #(
    parameter int unsigned SLICE_W = 16,
    parameter int unsigned NSLICE  = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        acc,
    input  logic [SLICE_W*NSLICE-1:0]   a,
    input  logic [SLICE_W*NSLICE-1:0]   b,
    input  logic                        cin,
    output logic                        busy,
    output logic                        done,
    output logic [SLICE_W*NSLICE-1:0]   sum,
    output logic                        cout
);

    localparam int unsigned W    = SLICE_W * NSLICE;
    localparam int unsigned CntW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(NSLICE - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e                           state_q, state_d;
    logic [CntW-1:0]                  cnt_q, cnt_d;
    logic [NSLICE-1:0][SLICE_W-1:0]   opa_q, opa_d;
    logic [NSLICE-1:0][SLICE_W-1:0]   opb_q, opb_d;
    logic [NSLICE-1:0][SLICE_W-1:0]   part_q, part_d;
    logic                             carry_q, carry_d;
    logic [W-1:0]                     sum_q, sum_d;
    logic                             cout_q, cout_d;

    logic [SLICE_W-1:0]               slice_sum;
    logic                             slice_cout;
    logic                             launch;

    // Shared slice adder (fa16bit_sc equivalent).
    always_comb begin
        {slice_cout, slice_sum} = {1'b0, opa_q[cnt_q]} + {1'b0, opb_q[cnt_q]}
                                + {{SLICE_W{1'b0}}, carry_q};
    end

    assign launch = start && (state_q != StRun);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        part_d  = part_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        busy    = 1'b0;
        done    = 1'b0;

        unique case (state_q)
            StIdle: ;
            StRun: begin
                busy           = 1'b1;
                part_d[cnt_q]  = slice_sum;
                carry_d        = slice_cout;
                if (cnt_q == LastCnt) begin
                    state_d = StDone;
                    sum_d   = part_d;
                    cout_d  = slice_cout;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Accumulate takes the visible sum, so a start in DONE chains the fresh result.
        if (launch) begin
            opa_d   = a;
            opb_d   = acc ? sum_q : b;
            carry_d = cin;
            cnt_d   = '0;
            state_d = StRun;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            part_q  <= part_d;
            carry_q <= carry_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_add48_seq_ctrl.sv
// Bench for add48_seq_ctrl: vector table plus hand sequences for accumulate,
// start-during-run and mid-run reset; results checked through an expected-result queue.
module tb_add48_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        acc;
    logic [47:0] a;
    logic [47:0] b;
    logic        cin;
    logic        busy;
    logic        done;
    logic [47:0] sum;
    logic        cout;

    add48_seq_ctrl dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .acc   (acc),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] a;
        logic [47:0] b;
        logic        cin;
        logic [47:0] exp_sum;
        logic        exp_cout;
    } vec_t;

    typedef struct {
        logic [47:0] s;
        logic        c;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[8];
    int   total = 0;
    int   bad   = 0;
    int   ndone = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Scoreboard consumer: every done pulse must match the oldest outstanding start.
    always @(negedge clk) begin
        if (!rst && done) begin
            exp_t e;
            ndone++;
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_done: got sum %h want no done", sum);
            end else begin
                e = sb.pop_front();
                chk("sum", 64'(sum), 64'(e.s));
                chk("cout", 64'(cout), 64'(e.c));
            end
        end
    end

    // Called at a negedge; start is seen at the next posedge, returns at the following negedge.
    task automatic drive_start(input logic [47:0] ta, input logic [47:0] tb_v, input logic tcin,
                               input logic tacc, input logic [47:0] es, input logic ec);
        exp_t e;
        a     = ta;
        b     = tb_v;
        cin   = tcin;
        acc   = tacc;
        start = 1'b1;
        e.s   = es;
        e.c   = ec;
        sb.push_back(e);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int exp_cyc, input int exp_busy);
        int          cyc   = 0;
        int          nb    = 0;
        logic        moved = 1'b0;
        logic [47:0] s0    = sum;
        while (!done && cyc < 20) begin
            if (busy) begin
                nb++;
                if (sum !== s0) moved = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no done after %0d cycles want done", name, cyc);
        end else begin
            chk({name, "_latency"}, 64'(cyc), 64'(exp_cyc));
            chk({name, "_busy_cycles"}, 64'(nb), 64'(exp_busy));
            chk({name, "_sum_stable"}, 64'(moved), 64'(0));
        end
    endtask

    initial begin
        int nd0;
        vecs[0] = '{48'h0000_0000_0001, 48'h0000_0000_0002, 1'b0, 48'h0000_0000_0003, 1'b0};
        vecs[1] = '{48'h0000_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 48'h0001_0000_0000, 1'b0};
        vecs[2] = '{48'h0000_FFFF_FFFF, 48'h0000_0000_0000, 1'b1, 48'h0001_0000_0000, 1'b0};
        vecs[3] = '{48'hFFFF_FFFF_FFFF, 48'h0000_0000_0001, 1'b0, 48'h0000_0000_0000, 1'b1};
        vecs[4] = '{48'h0000_0000_0000, 48'h0000_0000_0000, 1'b0, 48'h0000_0000_0000, 1'b0};
        vecs[5] = '{48'h1234_5678_9ABC, 48'h0FED_CBA9_8765, 1'b1, 48'h2222_2222_2222, 1'b0};
        vecs[6] = '{48'h8000_0000_0000, 48'h8000_0000_0000, 1'b0, 48'h0000_0000_0000, 1'b1};
        vecs[7] = '{48'hFFFF_0000_FFFF, 48'h0000_FFFF_0001, 1'b0, 48'h0000_0000_0000, 1'b1};

        rst   = 1'b1;
        start = 1'b0;
        acc   = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
        #12;
        chk("reset_outputs", 64'({busy, done, cout, sum}), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            drive_start(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].exp_sum,
                        vecs[i].exp_cout);
            wait_done($sformatf("vec%0d", i), 3, 3);
            @(negedge clk);
            chk($sformatf("vec%0d_done_one_cycle", i), 64'({busy, done}), 64'(0));
        end

        // Accumulate chained from the DONE cycle; b must be ignored.
        drive_start(48'd5, 48'd7, 1'b0, 1'b0, 48'd12, 1'b0);
        wait_done("acc_first", 3, 3);
        drive_start(48'd10, 48'hDEAD, 1'b0, 1'b1, 48'd22, 1'b0);
        chk("acc_sum_holds", 64'(sum), 64'd12);
        wait_done("acc_second", 3, 3);
        @(negedge clk);
        chk("acc_done_one_cycle", 64'(done), 64'(0));

        // start held during the later RUN cycles must be dropped, not queued.
        drive_start(48'd1, 48'd1, 1'b0, 1'b0, 48'd2, 1'b0);
        a     = 48'hFFFF_FFFF_FFFF;
        b     = 48'hFFFF_FFFF_FFFF;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("run_start_sum_unchanged", 64'(sum), 64'd22);
        nd0 = ndone;
        wait_done("run_start", 1, 1);
        @(negedge clk);
        chk("run_start_no_restart", 64'({busy, done}), 64'(0));
        repeat (4) @(negedge clk);
        chk("run_start_one_done", 64'(ndone - nd0), 64'd1);

        // Asynchronous reset in the middle of an operation.
        drive_start(48'd3, 48'd4, 1'b0, 1'b0, 48'd7, 1'b0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrun_reset_outputs", 64'({busy, done, cout, sum}), 64'(0));
        sb.delete();
        #1 rst = 1'b0;
        nd0 = ndone;
        repeat (6) @(negedge clk);
        chk("midrun_reset_no_done", 64'(ndone - nd0), 64'(0));
        drive_start(48'd9, 48'd9, 1'b0, 1'b0, 48'd18, 1'b0);
        wait_done("after_reset", 3, 3);
        @(negedge clk);

        chk("scoreboard_empty", 64'(sb.size()), 64'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
